// File: rtl/serial_word_rx16.sv
// Serial-to-parallel word receiver with a one-word output buffer.
// Optional macro PARITY_EN adds an even-parity bit and parity_err.
module serial_word_rx16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             lsb_first,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             q_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             busy,
`ifdef PARITY_EN
  output logic             parity_err,
`endif
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] sreg;
  logic            lsb_r;

  logic            take_bit;
  logic            last_bit;
  logic            order;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] sreg_nx;
  logic            complete;
  logic [WIDTH-1:0] word;
  logic            load;
`ifdef PARITY_EN
  logic            par_bit;
  logic            perr_nx;
`endif

  // Bit acceptance and the shifted register value for this cycle
  always_comb begin
    take_bit = sin_valid && (start || state == SHIFT);
    last_bit = (state == SHIFT) && !start && sin_valid
               && (cnt == LAST);
    order    = start ? lsb_first : lsb_r;
    base     = start ? '0 : sreg;
    if (order)
      sreg_nx = {sin, base[WIDTH-1:1]};
    else
      sreg_nx = {base[WIDTH-2:0], sin};
  end

`ifdef PARITY_EN
  // Word completes on the parity bit; register already holds the word
  always_comb begin
    par_bit  = (state == PARITY) && !start && sin_valid;
    complete = par_bit;
    word     = sreg;
    perr_nx  = (^sreg) ^ sin;
  end
`else
  // Word completes on the sixteenth accepted bit
  always_comb begin
    complete = last_bit;
    word     = sreg_nx;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic; start always restarts a frame
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = SHIFT;
      end
      SHIFT: begin
        if (start)
          state_nx = SHIFT;
        else if (last_bit)
`ifdef PARITY_EN
          state_nx = PARITY;
`else
          state_nx = IDLE;
`endif
      end
`ifdef PARITY_EN
      PARITY: begin
        if (start)
          state_nx = SHIFT;
        else if (par_bit)
          state_nx = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    busy = (state != IDLE);
  end

  // Shift register, bit counter and latched bit order
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg  <= '0;
      cnt   <= '0;
      lsb_r <= 1'b0;
    end else if (start) begin
      lsb_r <= lsb_first;
      sreg  <= take_bit ? sreg_nx : '0;
      cnt   <= take_bit ? CW'(1) : '0;
    end else if (state == SHIFT && sin_valid) begin
      sreg <= sreg_nx;
      cnt  <= cnt + CW'(1);
    end
  end

  // A completed word loads only if the buffer is free or draining
  always_comb begin
    load = complete && (!q_valid || q_ready);
  end

  // Output buffer, valid flag and sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
`ifdef PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (load) begin
        q <= word;
`ifdef PARITY_EN
        parity_err <= perr_nx;
`endif
      end
      if (complete && q_valid && !q_ready)
        overrun <= 1'b1;
      q_valid <= complete || (q_valid && !q_ready);
    end
  end

endmodule

// File: doc/serial_word_rx16.md
SERIAL_WORD_RX16 -- requirements
Module: serial_word_rx16

Interface
REQ-001 The block SHALL have one clock `clk` and reset `rst`; `rst` SHALL be asynchronous and active-high.
REQ-002 Parameter: WIDTH, 16, word length in bits; all requirements below assume WIDTH=16.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  frame start strobe.
REQ-006 lsb_first  input  1  bit order for the frame (0 = MSB first, 1 = LSB first); sampled only with start.
REQ-007 sin  input  1  serial data bit.
REQ-008 sin_valid  input  1  sin qualifier; one bit is accepted per cycle when high.
REQ-009 q  output  16  received word.
REQ-010 q_valid  output  1  q holds an unconsumed word.
REQ-011 q_ready  input  1  consumer accepts q when q_valid && q_ready.
REQ-012 busy  output  1  frame in progress (state != IDLE).
REQ-013 overrun  output  1  sticky flag: a completed word was dropped.

Function
REQ-014 FSM states SHALL be IDLE and SHIFT, plus PARITY when PARITY_EN is defined.
REQ-015 IDLE: on start=1, the block SHALL go to SHIFT, clear the bit counter, and latch lsb_first. sin_valid=1 in the same cycle SHALL be captured as bit 0.
REQ-016 IDLE without start: sin_valid SHALL be ignored.
REQ-017 SHIFT, MSB-first: each accepted bit SHALL do sreg <= {sreg[14:0], sin}.
REQ-018 SHIFT, LSB-first: each accepted bit SHALL do sreg <= {sin, sreg[15:1]}.
REQ-019 A 5-bit counter SHALL count accepted bits. The edge that accepts bit 16 SHALL complete the word and go to IDLE (or to PARITY if PARITY_EN).
REQ-020 Delivery on completion: the word SHALL load into q and q_valid SHALL be 1 from the following cycle, giving zero added latency.
REQ-021 Completion while q_valid=1 and q_ready=0: q SHALL be unchanged, the new word discarded, and overrun set.
REQ-022 Completion in the same cycle as q_valid && q_ready: the new word SHALL load and q_valid SHALL stay 1 with no overrun.
REQ-023 q_valid && q_ready with no completion: q_valid SHALL clear on that edge. q SHALL hold its value.
REQ-024 start during SHIFT/PARITY SHALL discard the partial frame and restart as in REQ-015. The output buffer SHALL be unaffected.
REQ-025 Frame reception SHALL continue while q_valid=1, so one word is buffered.
REQ-026 overrun SHALL clear only on rst.

Reset
REQ-027 On rst=1 the block SHALL immediately set: state IDLE, counter 0, sreg 0, q 16'h0000, q_valid 0, busy 0, overrun 0, and parity_err 0 when present.
REQ-028 rst mid-frame SHALL discard the partial frame and the buffered word. The first frame after reset SHALL need a new start.

Configuration
REQ-029 Macro PARITY_EN: when defined, the output port `parity_err  output  1` SHALL exist, and after bit 16 the FSM SHALL enter PARITY to accept one even-parity bit.
REQ-030 With PARITY_EN, the word SHALL be delivered on the parity-bit edge. parity_err SHALL load with q and equal 1 when the XOR of all 17 bits is 1.
REQ-031 Without PARITY_EN there SHALL be no parity_err port and no PARITY state, and delivery follows REQ-019.

Verification
REQ-032 Reset mid-frame: rst pulse after 7 bits -> q=0000, q_valid=0, busy=0 immediately; the next 16-bit frame after start is received correctly.
REQ-033 MSB-first: start, lsb_first=0, bits of A5A5 MSB first on consecutive cycles -> q=A5A5, q_valid=1 in the cycle after bit 16, busy=0.
REQ-034 LSB-first: start, lsb_first=1, stream 0000000011111111 (first to last) -> q=FF00.
REQ-035 Overrun and restart:
  - Frame 1234 completes with q_ready=0, then frame BEEF completes -> q=1234, overrun=1.
  - start after 5 bits of a frame, then a full frame 00F0 -> q=00F0.
REQ-036 Back-to-back: q_ready=1 on the completion edge of a second frame 5A5A -> q=5A5A, q_valid continuously 1, overrun=0.
REQ-037 PARITY_EN: A5A5 plus parity bit 0 -> parity_err=0; A5A5 plus parity bit 1 -> parity_err=1, q=A5A5.
